gc_dram_host_port: RTL

- Initiator-side port that drives the GC-DRAM array user interface: `we`, `re`, `waddr`, `raddr`, `data_in`, and receives `rd`.
- Accepts read/write requests from a client over a valid/ready channel and buffers them in a request FIFO.
- Issues requests to the array subject to read-after-write spacing and response credits.
- Captures `rd` after the fixed array read latency and returns read data on a valid/ready response channel.

---
 rtl/gc_dram_host_pkg.sv | 24 ++
 rtl/gc_dram_host_port_sync_fifo.sv | 60 ++++++
 rtl/gc_dram_host_port.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/gc_dram_host_pkg.sv
// Shared types and sizing helpers for the GC-DRAM host port.
package gc_dram_host_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 64;

  // Request FIFO payload; field widths follow the package defaults.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } req_t;

  // Width able to hold the values 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for a depth-entry memory, at least one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/gc_dram_host_port_sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full is accepted when a pop happens in the same cycle.
module sync_fifo
  import gc_dram_host_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gc_dram_host_port.sv
// Initiator port for the GC-DRAM array: queues client requests, issues them in order
// under read-after-write spacing and response credits, and returns read data.
module gc_dram_host_port
  import gc_dram_host_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned RAW_WIN   = 2,
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              we,
  output logic              re,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] rd,
  output logic              idle
);

  localparam int unsigned REQ_CW = cnt_w(REQ_DEPTH);
  localparam int unsigned RSP_CW = cnt_w(RSP_DEPTH);
  localparam int unsigned OCC_W  = cnt_w(RSP_DEPTH + RD_LAT + 1);

  req_t              req_in;
  req_t              head;
  logic              req_pop;
  logic              req_full;
  logic              req_empty;
  logic [REQ_CW-1:0] req_count;

  logic              rsp_push;
  logic              rsp_pop;
  logic              rsp_full;
  logic              rsp_empty;
  logic [RSP_CW-1:0] rsp_count;

  logic [RD_LAT:1]   vpipe;
  logic              hist_v [RAW_WIN];
  logic [ADDR_W-1:0] hist_a [RAW_WIN];

  logic              raw_hit;
  logic              credit_ok;
  logic              issue;
  logic [OCC_W-1:0]  occ;
  logic              unused_c;

  assign req_in    = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign req_ready = !req_full;
  assign rsp_valid = !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_push  = vpipe[RD_LAT];
  assign unused_c  = ^{req_count, rsp_full};

  sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid && req_ready),
    .pop   (req_pop),
    .wdata (req_in),
    .rdata (head),
    .full  (req_full),
    .empty (req_empty),
    .count (req_count)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .pop   (rsp_pop),
    .wdata (rd),
    .rdata (rsp_rdata),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  // Head read collides with a write issued within the last RAW_WIN cycles.
  always_comb begin
    raw_hit = 1'b0;
    for (int unsigned i = 0; i < RAW_WIN; i++) begin
      if (hist_v[i] && (hist_a[i] == head.addr)) begin
        raw_hit = 1'b1;
      end
    end
  end

  // Slots already claimed in the response FIFO: stored entries plus every read still in the pipe.
  always_comb begin
    occ       = OCC_W'(rsp_count) + OCC_W'(re) + OCC_W'($countones(vpipe));
    credit_ok = (occ < OCC_W'(RSP_DEPTH));
    issue     = !req_empty && (head.we || (!raw_hit && credit_ok));
    req_pop   = issue;
  end

  // Array command registers; address/data hold their last value between operations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we      <= 1'b0;
      re      <= 1'b0;
      waddr   <= '0;
      raddr   <= '0;
      data_in <= '0;
    end else begin
      we <= issue && head.we;
      re <= issue && !head.we;
      if (issue && head.we) begin
        waddr   <= head.addr;
        data_in <= head.wdata;
      end
      if (issue && !head.we) begin
        raddr <= head.addr;
      end
    end
  end

  // Read-valid pipe, write history and idle flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe  <= '0;
      hist_v <= '{default: 1'b0};
      hist_a <= '{default: '0};
      idle   <= 1'b1;
    end else begin
      vpipe     <= (vpipe << 1) | RD_LAT'(re);
      hist_v[0] <= issue && head.we;
      hist_a[0] <= head.addr;
      for (int unsigned i = 1; i < RAW_WIN; i++) begin
        hist_v[i] <= hist_v[i-1];
        hist_a[i] <= hist_a[i-1];
      end
      idle <= req_empty && rsp_empty && !re && (vpipe == '0);
    end
  end

endmodule
